// File: rtl/fir_result_capture_if.sv
// fir_result_capture_if: filter-result input stream plus valid/ready drained-word output stream
//   din/din_valid   : signed filter result and its strobe (no backpressure)
//   dout/dout_valid : registered drained word and its valid flag
//   dout_ready      : consumer accepts dout this cycle
interface fir_result_capture_if #(
  parameter int IN_W  = 65,
  parameter int OUT_W = 16
);
  logic signed [IN_W-1:0]  din;
  logic                    din_valid;
  logic signed [OUT_W-1:0] dout;
  logic                    dout_valid;
  logic                    dout_ready;
  modport master (output din, din_valid, dout_ready, input dout, dout_valid);
  modport slave  (input din, din_valid, dout_ready, output dout, dout_valid);
endinterface

// File: rtl/fir_result_capture.sv
// fir_result_capture: drop FIR warm-up samples, scale+saturate, buffer one frame, drain via valid/ready
//   clk, rst  : single clock, asynchronous active-high reset
//   start     : capture request, honoured in IDLE or DONE only
//   s         : input stream (din/din_valid) and output stream (dout/dout_valid/dout_ready)
//   busy      : high in SKIP, CAPTURE and DRAIN
//   done      : level, high in DONE
//   ovf_count : saturated samples in the current frame, sticky at 255
module fir_result_capture #(
  parameter int IN_W  = 65,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int DEPTH = 200,
  parameter int SKIP  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  fir_result_capture_if.slave        s,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 ovf_count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic signed [IN_W-1:0] MAXV = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MINV = ~MAXV;
  typedef enum logic [2:0] {S_IDLE, S_SKIP, S_CAPTURE, S_DRAIN, S_DONE} state_t;
  state_t state, nxt;
  logic [OUT_W-1:0] mem [DEPTH];
  logic [OUT_W-1:0] rd_data, sat;
  logic [AW-1:0] wr_ptr, rd_addr;
  logic [7:0] skip_cnt;
  logic signed [IN_W-1:0] q;
  logic rd_vld, rd_all, hi, lo, go, wr, last_wr, hs, load, ren;
  assign go      = start && (state == S_IDLE || state == S_DONE);
  assign q       = s.din >>> SHIFT;
  assign hi      = q > MAXV;
  assign lo      = q < MINV;
  assign sat     = hi ? {1'b0, {(OUT_W-1){1'b1}}} : lo ? {1'b1, {(OUT_W-1){1'b0}}} : q[OUT_W-1:0];
  assign wr      = state == S_CAPTURE && s.din_valid;
  assign last_wr = wr && wr_ptr == AW'(DEPTH-1);
  assign hs      = s.dout_valid && s.dout_ready;
  // rd_data is a one-word prefetch stage between the RAM and the output register
  assign load    = rd_vld && (!s.dout_valid || s.dout_ready);
  assign ren     = state == S_DRAIN && !rd_all && (!rd_vld || load);
  assign busy    = state inside {S_SKIP, S_CAPTURE, S_DRAIN};
  assign done    = state == S_DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE: nxt = start ? (SKIP == 0 ? S_CAPTURE : S_SKIP) : state;
      S_SKIP:         nxt = s.din_valid && skip_cnt == 8'(SKIP-1) ? S_CAPTURE : state;
      S_CAPTURE:      nxt = last_wr ? S_DRAIN : state;
      // the last word is in dout once every word has been read and the prefetch is empty
      S_DRAIN:        nxt = hs && rd_all && !rd_vld ? S_DONE : state;
      default:        nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_addr      <= '0;
      skip_cnt     <= '0;
      ovf_count    <= '0;
      rd_vld       <= 1'b0;
      rd_all       <= 1'b0;
      s.dout       <= '0;
      s.dout_valid <= 1'b0;
    end else begin
      if (go) begin
        wr_ptr    <= '0;
        rd_addr   <= '0;
        skip_cnt  <= '0;
        ovf_count <= '0;
        rd_vld    <= 1'b0;
        rd_all    <= 1'b0;
      end
      if (state == S_SKIP && s.din_valid) skip_cnt <= skip_cnt + 8'd1;
      if (wr) begin
        wr_ptr <= wr_ptr + AW'(1);
        if ((hi || lo) && ovf_count != 8'hff) ovf_count <= ovf_count + 8'd1;
      end
      if (ren) begin
        rd_addr <= rd_addr + AW'(1);
        rd_all  <= rd_addr == AW'(DEPTH-1);
        rd_vld  <= 1'b1;
      end else if (load) rd_vld <= 1'b0;
      if (load) begin
        s.dout       <= rd_data;
        s.dout_valid <= 1'b1;
      end else if (hs) s.dout_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (wr)  mem[wr_ptr] <= sat;
    if (ren) rd_data <= mem[rd_addr];
  end
endmodule

// File: tb/tb_fir_result_capture.sv
// tb_fir_result_capture: directed scoreboard bench for the default frame and the SKIP=0/DEPTH=1 corner
module tb_fir_result_capture;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic start, din_valid, dout_ready, sel;
  logic signed [64:0] din;
  logic busy_a, busy_b, done_a, done_b;
  logic [7:0] ovf_a, ovf_b;
  int errs = 0;
  int checks = 0;
  int cur_skip;
  logic signed [15:0] q[$];
  fir_result_capture_if #(.IN_W(65), .OUT_W(16)) ifa (), ifb ();
  assign ifa.din = din;
  assign ifa.din_valid = din_valid;
  assign ifa.dout_ready = dout_ready;
  assign ifb.din = din;
  assign ifb.din_valid = din_valid;
  assign ifb.dout_ready = dout_ready;
  fir_result_capture #(.IN_W(65), .OUT_W(16), .SHIFT(15), .DEPTH(200), .SKIP(8)) dut_a (
    .clk(clk), .rst(rst), .start(start && !sel), .s(ifa), .busy(busy_a), .done(done_a), .ovf_count(ovf_a));
  fir_result_capture #(.IN_W(65), .OUT_W(16), .SHIFT(15), .DEPTH(1), .SKIP(0)) dut_b (
    .clk(clk), .rst(rst), .start(start && sel), .s(ifb), .busy(busy_b), .done(done_b), .ovf_count(ovf_b));
  logic signed [15:0] o_dout;
  logic o_valid, o_busy, o_done;
  logic [7:0] o_ovf;
  assign o_dout  = sel ? ifb.dout : ifa.dout;
  assign o_valid = sel ? ifb.dout_valid : ifa.dout_valid;
  assign o_busy  = sel ? busy_b : busy_a;
  assign o_done  = sel ? done_b : done_a;
  assign o_ovf   = sel ? ovf_b : ovf_a;
  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic logic signed [15:0] model(input logic signed [64:0] d);
    logic signed [64:0] v;
    v = d >>> 15;
    return v > 32767 ? 16'sh7fff : v < -32768 ? 16'sh8000 : v[15:0];
  endfunction
  function automatic logic signed [64:0] val(input int kind, input int i);
    int j;
    j = i - cur_skip;
    if (kind == 0) return 65'(i) <<< 15;
    if (kind == 2) return 65'(i * 3 - 1234) <<< 15;
    if (i < cur_skip) return 65'sd1 <<< 50;
    case (j)
      0: return 65'sd1 <<< 40;
      1: return -(65'sd1 <<< 40);
      2: return 65'sd32767 <<< 15;
      3: return -(65'sd32768 <<< 15);
      default: return 65'(j - 100) <<< 15;
    endcase
  endfunction
  task automatic check_reset(input string tag);
    chk({tag, "_dout"}, o_dout, 0);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_ovf"}, o_ovf, 0);
  endtask
  task automatic go();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", o_busy, 1);
    chk("start_done", o_done, 0);
    chk("start_ovf_clear", o_ovf, 0);
  endtask
  task automatic feed(input int kind, input int n, input bit toggle, input int start_at);
    int acc = 0;
    int k = 0;
    bit st;
    while (acc < n) begin
      din_valid = toggle ? (k % 2 == 1) : 1'b1;
      din = din_valid ? val(kind, acc) : (65'sd1 <<< 45);
      st = din_valid && acc == start_at;
      start = st;
      if (din_valid) begin
        if (acc >= cur_skip) q.push_back(model(din));
        acc++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      k++;
      if (st) chk("start_mid_capture_busy", o_busy, 1);
    end
    din_valid = 1'b0;
  endtask
  task automatic drain(input bit slow, input int start_at, input string tag);
    int cyc = 0;
    int lat = -1;
    int gaps = 0;
    int hs = 0;
    logic signed [15:0] prev = 16'sd0;
    bit hold = 1'b0;
    bit r;
    while (q.size() > 0 && cyc < 3000) begin
      if (o_valid && lat < 0) lat = cyc;
      if (hold) begin
        chk({tag, "_hold_dout"}, o_dout, prev);
        chk({tag, "_hold_valid"}, o_valid, 1);
      end
      if (lat >= 0 && !o_valid && !slow) gaps++;
      r = slow ? (cyc % 3 == 2) : 1'b1;
      dout_ready = r;
      start = hs == start_at;
      if (o_valid && r) begin
        chk({tag, "_data"}, o_dout, q.pop_front());
        hs++;
      end
      hold = o_valid && !r;
      prev = o_dout;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    dout_ready = 1'b0;
    chk({tag, "_all_drained"}, q.size(), 0);
    chk({tag, "_first_valid_latency"}, lat, 2);
    if (!slow) chk({tag, "_gaps"}, gaps, 0);
    chk({tag, "_end_done"}, o_done, 1);
    chk({tag, "_end_busy"}, o_busy, 0);
    chk({tag, "_end_valid"}, o_valid, 0);
  endtask
  initial begin
    start = 1'b0;
    din = '0;
    din_valid = 1'b0;
    dout_ready = 1'b0;
    sel = 1'b0;
    cur_skip = 8;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    go();
    feed(0, 208, 1'b0, -1);
    chk("basic_ovf", o_ovf, 0);
    drain(1'b0, -1, "basic");
    go();
    feed(1, 208, 1'b0, -1);
    chk("sat_ovf", o_ovf, 2);
    drain(1'b0, -1, "sat");
    go();
    feed(0, 208, 1'b1, 50);
    chk("stall_ovf", o_ovf, 0);
    drain(1'b1, 100, "stall");
    chk("stall_ovf_end", o_ovf, 0);
    go();
    feed(1, 108, 1'b0, -1);
    chk("partial_busy", o_busy, 1);
    chk("partial_ovf", o_ovf, 2);
    rst = 1'b1;
    #2;
    check_reset("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    @(posedge clk); #1;
    chk("after_rst_idle_done", o_done, 0);
    go();
    feed(0, 208, 1'b0, -1);
    drain(1'b0, -1, "after_rst");
    sel = 1'b1;
    cur_skip = 0;
    chk("edge_idle_busy", o_busy, 0);
    go();
    feed(1, 1, 1'b0, -1);
    chk("edge_ovf", o_ovf, 1);
    drain(1'b0, -1, "edge1");
    go();
    feed(2, 1, 1'b1, -1);
    chk("edge2_ovf", o_ovf, 0);
    drain(1'b1, -1, "edge2");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
